input_vc_buffer: RTL and testbench

//  Per-input-port virtual-channel buffer, one instance per router input port.

---
 rtl/input_vc_buffer_pkg.sv | 16 +
 rtl/vc_fifo.sv | 52 +++++
 rtl/input_vc_buffer.sv | 93 +++++++++
 tb/tb_input_vc_buffer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/input_vc_buffer_pkg.sv
// Shared router constants and types for the per-input-port virtual-channel buffer.
package input_vc_buffer_pkg;

  localparam int CH_BITS      = 8;
  localparam int NUM_VCS      = 2;
  localparam int VC_ID_BITS   = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
  localparam int VC_BUF_DEPTH = 4;

  typedef logic [CH_BITS-1:0] flit_t;

  // Pointer width: one extra MSB beyond the address tells full from empty.
  function automatic int ptr_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel circular FIFO; head entry is read straight from storage.
module vc_fifo
  import input_vc_buffer_pkg::*;
#(
  parameter int WIDTH = CH_BITS,
  parameter int DEPTH = VC_BUF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int PW = ptr_bits(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A write into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // NOTE: the data array has no reset; emptiness is tracked by the pointers alone,
  // so clearing storage would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/input_vc_buffer.sv
// Per-input-port VC buffer: write demux, NUM_VCS FIFOs, credit return and sticky overflow flag.
// Optional same-cycle bypass of an empty VC is enabled by defining VCBUF_BYPASS_EN.
module input_vc_buffer
  import input_vc_buffer_pkg::*;
#(
  parameter int PORT_BANDWIDTH = CH_BITS,
  parameter int BUF_DEPTH      = VC_BUF_DEPTH
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [PORT_BANDWIDTH-1:0]               in_flit,
  input  logic                                    in_valid,
  input  logic [VC_ID_BITS-1:0]                   in_vc,
  input  logic [NUM_VCS-1:0]                      rd_en,
  output logic [NUM_VCS-1:0][PORT_BANDWIDTH-1:0]  head_flit,
  output logic [NUM_VCS-1:0]                      head_valid,
  output logic [NUM_VCS-1:0]                      credit_out,
  output logic                                    overflow_err
);

  logic [NUM_VCS-1:0]                     wr_sel;
  logic [NUM_VCS-1:0]                     wr_en;
  logic [NUM_VCS-1:0]                     fifo_pop;
  logic [NUM_VCS-1:0]                     fifo_empty;
  logic [NUM_VCS-1:0]                     fifo_full;
  logic [NUM_VCS-1:0]                     bypass_take;
  logic [NUM_VCS-1:0][PORT_BANDWIDTH-1:0] fifo_data;
  logic                                   vc_in_range;
  logic                                   overflow_set;

  assign vc_in_range = int'(in_vc) < NUM_VCS;

  // NOTE: every signal gets a default at the top of the block so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_sel       = '0;
    wr_en        = '0;
    fifo_pop     = '0;
    bypass_take  = '0;
    overflow_set = in_valid && !vc_in_range;
    for (int v = 0; v < NUM_VCS; v++) begin
      wr_sel[v]   = in_valid && (int'(in_vc) == v);
      fifo_pop[v] = rd_en[v] && !fifo_empty[v];
`ifdef VCBUF_BYPASS_EN
      bypass_take[v] = wr_sel[v] && fifo_empty[v] && rd_en[v];
`endif
      // Full is judged after the same-cycle pop frees a slot.
      wr_en[v] = wr_sel[v] && !bypass_take[v] && (!fifo_full[v] || fifo_pop[v]);
      if (wr_sel[v] && fifo_full[v] && !fifo_pop[v]) overflow_set = 1'b1;
    end
  end

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    vc_fifo #(
      .WIDTH (PORT_BANDWIDTH),
      .DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[v]),
      .wr_data (in_flit),
      .rd_en   (fifo_pop[v]),
      .rd_data (fifo_data[v]),
      .empty   (fifo_empty[v]),
      .full    (fifo_full[v])
    );
  end

  always_comb begin
    head_valid = ~fifo_empty;
    head_flit  = fifo_data;
`ifdef VCBUF_BYPASS_EN
    for (int v = 0; v < NUM_VCS; v++) begin
      if (fifo_empty[v] && wr_sel[v]) begin
        head_valid[v] = 1'b1;
        head_flit[v]  = in_flit;
      end
    end
`endif
  end

  // Credits cover both stored pops and bypassed flits; flushed flits earn none.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_out   <= '0;
      overflow_err <= 1'b0;
    end else begin
      credit_out <= fifo_pop | bypass_take;
      if (overflow_set) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_input_vc_buffer.sv
// Directed bench for input_vc_buffer with a per-VC queue scoreboard (NUM_VCS=2, depth 4).
module tb_input_vc_buffer;

  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic [7:0]       in_flit;
  logic             in_valid;
  logic [0:0]       in_vc;
  logic [1:0]       rd_en;
  logic [1:0][7:0]  head_flit;
  logic [1:0]       head_valid;
  logic [1:0]       credit_out;
  logic             overflow_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [1:0] exp_credit = 2'b00;
  logic       exp_ovf    = 1'b0;

  input_vc_buffer #(
    .PORT_BANDWIDTH (8),
    .BUF_DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_flit      (in_flit),
    .in_valid     (in_valid),
    .in_vc        (in_vc),
    .rd_en        (rd_en),
    .head_flit    (head_flit),
    .head_valid   (head_valid),
    .credit_out   (credit_out),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sb_size(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [7:0] sb_front(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void sb_pop(input int i);
    if (i == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endfunction

  function automatic void sb_push(input int i, input logic [7:0] d);
    if (i == 0) q0.push_back(d);
    else        q1.push_back(d);
  endfunction

  // One clock of stimulus: drive at posedge+1, compare at negedge, update the model, advance.
  task automatic drive(input logic v, input logic vc, input logic [7:0] f, input logic [1:0] rd);
    logic [1:0] acc;
    logic       byp;
    logic [7:0] eh;
    logic       ehv;
    int         sz;
    in_valid = v;
    in_vc    = vc;
    in_flit  = f;
    rd_en    = rd;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sz  = sb_size(i);
      ehv = (sz != 0);
      eh  = (sz != 0) ? sb_front(i) : 8'h00;
`ifdef VCBUF_BYPASS_EN
      if (sz == 0 && v && int'(vc) == i) begin
        ehv = 1'b1;
        eh  = f;
      end
`endif
      check($sformatf("head_valid[%0d]", i), 32'(head_valid[i]), 32'(ehv));
      check($sformatf("head_flit[%0d]", i), 32'(head_flit[i]), 32'(eh));
    end
    check("credit_out", 32'(credit_out), 32'(exp_credit));
    check("overflow_err", 32'(overflow_err), 32'(exp_ovf));
    acc = 2'b00;
    byp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (rd[i] && sb_size(i) != 0) begin
        sb_pop(i);
        acc[i] = 1'b1;
      end
`ifdef VCBUF_BYPASS_EN
      else if (rd[i] && v && int'(vc) == i) begin
        acc[i] = 1'b1;
        byp    = 1'b1;
      end
`endif
    end
    if (v && !byp) begin
      if (sb_size(int'(vc)) < DEPTH) sb_push(int'(vc), f);
      else                           exp_ovf = 1'b1;
    end
    exp_credit = acc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rd_en    = 2'b00;
  endtask

  // Two-cycle reset with traffic still applied; nothing stored or popped may survive it.
  task automatic do_reset(input logic [1:0] rd);
    rst      = 1'b1;
    rd_en    = rd;
    in_valid = 1'b1;
    in_vc    = 1'b0;
    in_flit  = 8'hEE;
    @(posedge clk);
    #1;
    check("rst head_valid", 32'(head_valid), 32'h0);
    check("rst head_flit", 32'(head_flit), 32'h0);
    check("rst credit_out", 32'(credit_out), 32'h0);
    check("rst overflow_err", 32'(overflow_err), 32'h0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    rd_en    = 2'b00;
    q0.delete();
    q1.delete();
    exp_credit = 2'b00;
    exp_ovf    = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_flit  = 8'h00;
    in_valid = 1'b0;
    in_vc    = 1'b0;
    rd_en    = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("init head_valid", 32'(head_valid), 32'h0);
    check("init head_flit", 32'(head_flit), 32'h0);
    check("init credit_out", 32'(credit_out), 32'h0);
    check("init overflow_err", 32'(overflow_err), 32'h0);

    // Ordering on VC1, VC0 idle.
    drive(1'b1, 1'b1, 8'hA1, 2'b00);
    drive(1'b1, 1'b1, 8'hA2, 2'b00);
    drive(1'b1, 1'b1, 8'hA3, 2'b00);
    drive(1'b0, 1'b0, 8'h00, 2'b10);
    drive(1'b0, 1'b0, 8'h00, 2'b10);
    drive(1'b0, 1'b0, 8'h00, 2'b10);
    drive(1'b0, 1'b0, 8'h00, 2'b00);
    drive(1'b0, 1'b0, 8'h00, 2'b00);

    // Fill VC0 past capacity with no pops: fifth flit dropped, error sticks.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'(8'h10 + i), 2'b00);
    drive(1'b0, 1'b0, 8'h00, 2'b00);
    drive(1'b1, 1'b1, 8'h77, 2'b00);
    drive(1'b0, 1'b0, 8'h00, 2'b10);

    // Reset mid-traffic clears everything and returns no credits.
    do_reset(2'b11);
    drive(1'b0, 1'b0, 8'h00, 2'b00);

    // Fill again, fifth write coincides with a pop and is accepted.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(8'h20 + i), 2'b00);
    drive(1'b1, 1'b0, 8'h24, 2'b01);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'h00, 2'b01);
    drive(1'b0, 1'b0, 8'h00, 2'b00);

    // Pointer wrap on VC0 with VC1 traffic interleaved.
    drive(1'b1, 1'b0, 8'h30, 2'b00);
    drive(1'b1, 1'b0, 8'h31, 2'b00);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 8'(8'h32 + i), 2'b01);
      drive(1'b1, 1'b1, 8'(8'h60 + i), 2'b10);
    end

    // Concurrent pops, then pops on empty VCs.
    drive(1'b0, 1'b0, 8'h00, 2'b11);
    drive(1'b0, 1'b0, 8'h00, 2'b11);
    drive(1'b0, 1'b0, 8'h00, 2'b11);
    drive(1'b0, 1'b0, 8'h00, 2'b00);

    // Write to empty VC1 with a simultaneous pop request.
    drive(1'b1, 1'b1, 8'h55, 2'b10);
    drive(1'b0, 1'b0, 8'h00, 2'b00);
    drive(1'b0, 1'b0, 8'h00, 2'b10);
    drive(1'b0, 1'b0, 8'h00, 2'b00);
    drive(1'b0, 1'b0, 8'h00, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
